// File: rtl/prog_mem_loader_pkg.sv
// Shared types and default widths for the program memory loader slice.
package cpu_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} ldr_state_t;

  localparam int CPU_ADDR_W = 1;
  localparam int CPU_DATA_W = 1;

endpackage

// File: rtl/prog_mem_loader_if.sv
// Load port and cpu instruction port of the program memory loader.
interface prog_mem_loader_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
);
  logic              ld_start;
  logic              ld_valid;
  logic              ld_bit;
  logic              ld_ready;
  logic              ld_done;
  logic              ld_err;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              cpu_hold;

  modport master (
    output ld_start, ld_valid, ld_bit, addr,
    input  ld_ready, ld_done, ld_err, data, cpu_hold
  );

  modport slave (
    input  ld_start, ld_valid, ld_bit, addr,
    output ld_ready, ld_done, ld_err, data, cpu_hold
  );
endinterface

// File: rtl/prog_mem_loader_deser.sv
// Serial-to-parallel shifter: collects DATA_W bits LSB first and presents the
// completed word combinationally in the cycle its last bit arrives.
module prog_mem_loader_deser
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic [DATA_W-1:0] word,
  output logic              word_valid,
  output logic              last_bit
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;

  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (in_valid) begin
      shreg[bit_cnt] <= in_bit;
      bit_cnt        <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end

  // The final bit bypasses the shifter so the full word is ready this cycle.
  always_comb begin
    word             = shreg;
    word[DATA_W-1]   = in_bit;
    word_valid       = in_valid & last_bit & ~clear;
  end

endmodule

// File: rtl/prog_mem_loader.sv
// Program memory feeding the cpu: serial image load, cpu held in reset until
// a complete image is present, reload allowed at any time.
module prog_mem_loader
  import cpu_pkg::*;
#(
  parameter int               ADDR_W   = CPU_ADDR_W,
  parameter int               DATA_W   = CPU_DATA_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  prog_mem_loader_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  ldr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] word_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept, restart, done;
  logic              err_q, hold_q;
  logic [DATA_W-1:0] word;
  logic              word_valid, last_bit;

  prog_mem_loader_deser #(.DATA_W(DATA_W)) u_deser (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .in_valid   (accept),
    .in_bit     (bus.ld_bit),
    .word       (word),
    .word_valid (word_valid),
    .last_bit   (last_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Completing the image takes priority over a simultaneous ld_start;
  // otherwise a restart discards any bit offered in the same cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    restart   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ld_start) begin
          state_nxt = LOAD;
          restart   = 1'b1;
        end
      end
      LOAD: begin
        if (bus.ld_valid && last_bit && word_ptr == ADDR_W'(DEPTH - 1)) begin
          accept    = 1'b1;
          done      = 1'b1;
          state_nxt = RUN;
        end else if (bus.ld_start) begin
          restart = 1'b1;
        end else begin
          accept = bus.ld_valid;
        end
      end
      RUN: begin
        if (bus.ld_start) begin
          state_nxt = LOAD;
          restart   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_ptr <= '0;
    end else if (restart) begin
      word_ptr <= '0;
    end else if (word_valid) begin
      word_ptr <= word_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VAL;
    end else if (word_valid) begin
      mem[word_ptr] <= word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q  <= 1'b0;
      hold_q <= 1'b1;
    end else begin
      if (restart && state == LOAD) err_q <= 1'b1;
      hold_q <= (state_nxt != RUN);
    end
  end

  assign bus.ld_ready = (state == LOAD);
  assign bus.ld_done  = done;
  assign bus.ld_err   = err_q;
  assign bus.cpu_hold = hold_q;
  assign bus.data     = (state == RUN) ? mem[bus.addr] : '0;

endmodule
